// File: rtl/cq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cq_pkg
// Description : Shared defaults and width helper for the cq_param queue.
// Revision    : 1.0 - initial release
// ============================================================================
package cq_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_depth = 8;

    // Bits needed to encode values 0..value-1; returns 0 for value <= 1.
    function automatic int cq_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : cq_pkg
`default_nettype wire

// File: rtl/cq_ptr.sv
`default_nettype none
// ============================================================================
// Module      : cq_ptr
// Description : Modulo-DEPTH pointer with increment and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module cq_ptr
    import cq_pkg::*;
#(
    parameter int DEPTH = c_default_depth,
    parameter int PW    = cq_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] c_LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;

    // Explicit compare so non-power-of-two depths wrap correctly.
    always_comb begin
        w_ptr_next = r_ptr + PW'(1);
        if (r_ptr == c_LAST) begin
            w_ptr_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign ptr = r_ptr;

endmodule : cq_ptr
`default_nettype wire

// File: rtl/cq_param.sv
`default_nettype none
// ============================================================================
// Module      : cq_param
// Description : Parameterised synchronous circular queue with registered
//               read data, occupancy count and threshold flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cq_param
    import cq_pkg::*;
#(
    parameter int WIDTH    = c_default_width,
    parameter int DEPTH    = c_default_depth,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           wr,
    input  logic                           rd,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           rd_valid,
    output logic                           empty,
    output logic                           full,
    output logic                           almost_empty,
    output logic                           almost_full,
    output logic [cq_clog2(DEPTH+1)-1:0]   count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int PW = cq_clog2(DEPTH);
    localparam int CW = cq_clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_dout;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;
    logic [CW-1:0]    r_count;

    logic [PW-1:0]    w_wr_ptr;
    logic [PW-1:0]    w_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_wr_ok;
    logic             w_rd_ok;

    // Flags decode from the registered count only.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // A full queue still accepts a write when a read frees a slot the same edge.
    assign w_wr_ok = !reset && !clear && wr && (!w_full || rd);
    assign w_rd_ok = !reset && !clear && rd && !w_empty;

    cq_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (w_wr_ok),
        .ptr   (w_wr_ptr)
    );

    cq_ptr #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (w_rd_ok),
        .ptr   (w_rd_ptr)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout      <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_count     <= '0;
        end else if (clear) begin
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_count     <= '0;
        end else begin
            r_rd_valid  <= w_rd_ok;
            r_overflow  <= wr && !w_wr_ok;
            r_underflow <= rd && !w_rd_ok;
            if (w_rd_ok) begin
                r_dout <= r_mem[w_rd_ptr];
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout         = r_dout;
    assign rd_valid     = r_rd_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign almost_full  = (r_count >= CW'(AF_LEVEL));

endmodule : cq_param
`default_nettype wire

// File: tb/tb_cq_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_cq_param
// Description : Directed self-checking bench for cq_param (DEPTH 8 and 5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cq_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        wr;
    logic        rd;
    logic [15:0] din;

    logic [15:0] dout8, dout5;
    logic        rv8, rv5, em8, em5, fu8, fu5, ae8, ae5, af8, af5;
    logic        ov8, ov5, un8, un5;
    logic [3:0]  cnt8;
    logic [2:0]  cnt5;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cq_param dut8 (
        .clk(clk), .reset(reset), .clear(clear), .wr(wr), .rd(rd), .din(din),
        .dout(dout8), .rd_valid(rv8), .empty(em8), .full(fu8),
        .almost_empty(ae8), .almost_full(af8), .count(cnt8),
        .overflow(ov8), .underflow(un8)
    );

    cq_param #(.DEPTH(5)) dut5 (
        .clk(clk), .reset(reset), .clear(clear), .wr(wr), .rd(rd), .din(din),
        .dout(dout5), .rd_valid(rv5), .empty(em5), .full(fu5),
        .almost_empty(ae5), .almost_full(af5), .count(cnt5),
        .overflow(ov5), .underflow(un5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic w, input logic r, input logic [15:0] d);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = '0;
        #2;

        // Reset state
        do_reset();
        check("rst_empty", 32'(em8), 32'd1);
        check("rst_full", 32'(fu8), 32'd0);
        check("rst_ae", 32'(ae8), 32'd1);
        check("rst_af", 32'(af8), 32'd0);
        check("rst_count", 32'(cnt8), 32'd0);
        check("rst_dout", 32'(dout8), 32'd0);
        check("rst_flags", 32'({rv8, ov8, un8}), 32'd0);

        // Single write then read
        step(1'b1, 1'b0, 16'h000A);
        check("wr1_count", 32'(cnt8), 32'd1);
        check("wr1_rv", 32'(rv8), 32'd0);
        step(1'b0, 1'b1, 16'h0);
        check("rd1_dout", 32'(dout8), 32'h000A);
        check("rd1_rv", 32'(rv8), 32'd1);
        check("rd1_empty", 32'(em8), 32'd1);
        check("rd1_err", 32'({ov8, un8}), 32'd0);
        step(1'b0, 1'b0, 16'h0);
        check("rd1_rv_drop", 32'(rv8), 32'd0);
        check("rd1_dout_hold", 32'(dout8), 32'h000A);

        // DEPTH=5 fill, overflow, drain
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 16'(i));
        check("d5_full", 32'(fu5), 32'd1);
        check("d5_count", 32'(cnt5), 32'd5);
        step(1'b1, 1'b0, 16'd6);
        check("d5_ovf", 32'(ov5), 32'd1);
        check("d5_ovf_count", 32'(cnt5), 32'd5);
        step(1'b0, 1'b0, 16'h0);
        check("d5_ovf_drop", 32'(ov5), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 16'h0);
            check("d5_drain", 32'(dout5), 32'(i));
        end
        check("d5_drained", 32'(em5), 32'd1);

        // DEPTH=5 wrap with alternating write/read
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 16'(16'h10 + i));
            check("wrap_cnt_w", 32'(cnt5), 32'd1);
            step(1'b0, 1'b1, 16'h0);
            check("wrap_dout", 32'(dout5), 32'(16'h10 + i));
            check("wrap_cnt_r", 32'(cnt5), 32'd0);
        end

        // Simultaneous read/write while full, then while empty
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 16'(i));
        step(1'b1, 1'b1, 16'h0077);
        check("fullrw_dout", 32'(dout5), 32'd1);
        check("fullrw_count", 32'(cnt5), 32'd5);
        check("fullrw_err", 32'({ov5, un5}), 32'd0);
        for (int i = 2; i <= 6; i++) begin
            step(1'b0, 1'b1, 16'h0);
            check("fullrw_drain", 32'(dout5), (i == 6) ? 32'h77 : 32'(i));
        end
        step(1'b1, 1'b1, 16'h0055);
        check("emptyrw_unf", 32'(un5), 32'd1);
        check("emptyrw_count", 32'(cnt5), 32'd1);
        check("emptyrw_rv", 32'(rv5), 32'd0);
        check("emptyrw_dout", 32'(dout5), 32'h77);

        // Threshold flags with defaults (AF=6, AE=2)
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(i));
        check("af_at5", 32'(af8), 32'd0);
        step(1'b1, 1'b0, 16'h5);
        check("af_at6", 32'(af8), 32'd1);
        check("ae_at6", 32'(ae8), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0);
        check("cnt_at3", 32'(cnt8), 32'd3);
        check("flags_at3", 32'({af8, ae8}), 32'd0);
        step(1'b0, 1'b1, 16'h0);
        check("ae_at2", 32'(ae8), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'(i));
        check("d8_full", 32'(fu8), 32'd1);
        check("d8_count", 32'(cnt8), 32'd8);

        // Clear, then reset during a read
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'(16'h20 + i));
        step(1'b0, 1'b1, 16'h0);
        check("pre_clr_dout", 32'(dout8), 32'h21);
        clear = 1'b1;
        step(1'b1, 1'b1, 16'h0099);
        clear = 1'b0;
        check("clr_count", 32'(cnt8), 32'd0);
        check("clr_empty", 32'(em8), 32'd1);
        check("clr_dout", 32'(dout8), 32'h21);
        check("clr_pulses", 32'({rv8, ov8, un8}), 32'd0);
        step(1'b0, 1'b1, 16'h0);
        check("clr_unf", 32'(un8), 32'd1);
        step(1'b1, 1'b0, 16'h0031);
        step(1'b1, 1'b0, 16'h0032);
        reset = 1'b1;
        step(1'b0, 1'b1, 16'h0);
        reset = 1'b0;
        check("mrst_count", 32'(cnt8), 32'd0);
        check("mrst_empty", 32'(em8), 32'd1);
        check("mrst_dout", 32'(dout8), 32'd0);
        check("mrst_rv", 32'(rv8), 32'd0);
        step(1'b0, 1'b1, 16'h0);
        check("mrst_unf", 32'(un8), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cq_param
`default_nettype wire

// File: doc/cq_param.md
CQ_PARAM -- requirements
Module: cq_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 8: entry count, >=2, not required to be a power of two.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full threshold, 1..DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty threshold, 0..DEPTH-1.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port clear, input, 1 bit: synchronous flush of queue contents.
REQ-008 SHALL have port wr, input, 1 bit: write request.
REQ-009 SHALL have port rd, input, 1 bit: read request.
REQ-010 SHALL have port din, input, WIDTH bits: write data.
REQ-011 SHALL have port dout, output, WIDTH bits: registered read data.
REQ-012 SHALL have port rd_valid, output, 1 bit: one-cycle pulse; dout was loaded at the preceding edge.
REQ-013 SHALL have port empty, output, 1 bit: high when count==0.
REQ-014 SHALL have port full, output, 1 bit: high when count==DEPTH.
REQ-015 SHALL have port almost_empty, output, 1 bit: high when count<=AE_LEVEL.
REQ-016 SHALL have port almost_full, output, 1 bit: high when count>=AF_LEVEL.
REQ-017 SHALL have port count, output, clog2(DEPTH+1) bits: current occupancy.
REQ-018 SHALL have port overflow, output, 1 bit: one-cycle pulse when a write is refused.
REQ-019 SHALL have port underflow, output, 1 bit: one-cycle pulse when a read is refused.

Function
REQ-020 A write SHALL be accepted when wr=1 and (full=0, or rd=1 with full=1); din is stored at wr_ptr, and wr_ptr advances.
REQ-021 A read SHALL be accepted when rd=1 and empty=0; mem[rd_ptr] is loaded into dout at the same edge, rd_ptr advances, and rd_valid=1 in the following cycle.
REQ-022 Read latency SHALL be one cycle; dout SHALL hold its last value when no read is accepted.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 by explicit compare, never by binary overflow.
REQ-024 count SHALL change as follows: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
REQ-025 Full with wr=1 and rd=1: both SHALL be accepted; count stays DEPTH; the oldest word goes to dout.
REQ-026 Empty with wr=1 and rd=1: the write SHALL be accepted and the read refused (no fall-through); underflow pulses; count becomes 1.
REQ-027 wr=1 while full with rd=0 SHALL pulse overflow, with memory and pointers unchanged.
REQ-028 rd=1 while empty SHALL pulse underflow, with dout unchanged and rd_valid=0.
REQ-029 Flags and count SHALL be registered state or decoded from registered count only, with no combinational path from wr or rd.
REQ-030 clear=1 SHALL zero pointers and count and ignore wr/rd in that cycle; dout holds; rd_valid, overflow and underflow are 0 the next cycle.

Reset
REQ-031 reset=1 at an edge SHALL set wr_ptr=0, rd_ptr=0, count=0, dout=0, rd_valid=0, overflow=0, underflow=0.
REQ-032 After reset, empty=1, full=0, almost_empty=1, and almost_full=0.
REQ-033 reset SHALL take priority over clear, wr and rd; mid-operation reset discards all contents.
REQ-034 Memory array contents SHALL NOT be reset.

Structure
REQ-035 Package cq_pkg SHALL hold the default WIDTH/DEPTH constants and the clog2 helper used for pointer and count widths.
REQ-036 Sub-module cq_ptr (modulo-DEPTH pointer with inc and clr inputs) SHALL be instantiated twice, once as wr_ptr and once as rd_ptr.

Verification
REQ-037 Reset, then write 0xA, then read -> dout=0xA with rd_valid=1 one cycle after the read; empty=1 afterwards; no error pulses.
REQ-038 DEPTH=5: write 1..5 -> full=1, count=5; a 6th write of 6 -> overflow pulse; read 5 -> dout sequence 1,2,3,4,5.
REQ-039 DEPTH=5: perform 12 write/read pairs of values 0x10..0x1B -> outputs are in order through pointer wrap, count never exceeds 1.
REQ-040 Full queue, wr=1 and rd=1 with din=0x77 -> dout = oldest word, count stays DEPTH, 0x77 is read last; empty queue, wr=1 and rd=1 -> underflow pulse, count=1.
REQ-041 Defaults: fill to 6 -> almost_full=1; drain to 2 -> almost_empty=1; at 3 both are 0.
REQ-042 After 4 writes, assert clear, then separately assert reset during a read -> count=0, empty=1, the next read underflows.
